// File: rtl/four_digit_scan_ctrl.sv
// Purpose : time-multiplexed scan controller for a four-digit seven-segment display.
// Latency : outputs are registered and lag the internal slot counter / digit index by one cycle.
// Backpr. : none; a load strobe is always accepted, and a newer load overwrites an older pending value.
//
// Holds the displayed value in a shadow register. New values are double-buffered
// and applied only at frame boundaries (the end of digit 3's slot), so the display
// never shows a half-updated value.
//
// Optional feature, macro LEAD_ZERO_BLANK_EN: leading-zero blanking evaluated on
// the shadow value. Digit 0 is never blanked by this rule.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   scan enable; 0 freezes counters and blanks all anodes
//   value_in   in   [15:0] new display value, nibble i shown on digit i (digit 0 rightmost)
//   load       in   one-cycle strobe capturing value_in into the pending buffer
//   dp_in      in   [3:0] per-digit decimal-point request, active-high
//   blank_mask in   [3:0] bit i forces digit i dark
//   nib        out  [3:0] nibble of the current digit, feeds the hex decoder
//   an         out  [3:0] digit anodes, active-low (one-hot-low or all ones)
//   dp_n       out  decimal point, active-low
//   pending    out  a loaded value is waiting for the frame boundary
//   frame_tick out  one-cycle pulse after digit 3's slot ends

module four_digit_scan_ctrl #(
  parameter int PRESCALE = 50000,  // clk cycles per digit slot, >= 2
  parameter int GUARD    = 2       // blanking cycles at the start of each slot, 0..PRESCALE-1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_mask,
  output logic [3:0]  nib,
  output logic [3:0]  an,
  output logic        dp_n,
  output logic        pending,
  output logic        frame_tick
);

  localparam int            CW       = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [15:0]   pend_val;

  logic tc;        // last cycle of the current slot
  logic fb;        // last cycle of digit 3's slot: frame boundary
  logic in_guard;  // anti-ghosting blanking window at the start of a slot
  logic dark;      // current digit must stay unlit

  assign tc = en && (cnt == CNT_LAST);
  assign fb = tc && (idx == 2'd3);

  // With no guard window the comparison would be constant, so it is not built.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
      assign in_guard = (cnt < GUARD_C);
    end
  endgenerate

`ifdef LEAD_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more-significant nibble are zero.
  // The chain runs from digit 3 downwards; digit 0 always stays lit.
  logic [3:0] lz_dark;

  always_comb begin
    lz_dark    = 4'b0000;
    lz_dark[3] = (shadow[15:12] == 4'h0);
    lz_dark[2] = lz_dark[3] && (shadow[11:8] == 4'h0);
    lz_dark[1] = lz_dark[2] && (shadow[7:4]  == 4'h0);
  end

  assign dark = blank_mask[idx] | lz_dark[idx];
`else
  assign dark = blank_mask[idx];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      shadow     <= 16'h0000;
      pend_val   <= 16'h0000;
      pending    <= 1'b0;
      an         <= 4'b1111;
      nib        <= 4'h0;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      // Slot counter and digit index; both hold while scanning is disabled.
      if (tc) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else if (en) begin
        cnt <= cnt + CW'(1);
      end

      frame_tick <= fb;

      // Nibble and decimal point track the digit even while the anodes are blanked,
      // so the decoder output has settled before the digit lights up.
      nib  <= shadow[{idx, 2'b00} +: 4];
      dp_n <= ~dp_in[idx];

      if (!en || in_guard || dark) begin
        an <= 4'b1111;
      end else begin
        an <= ~(4'b0001 << idx);
      end

      // Double-buffered value update. A load coinciding with the frame boundary
      // bypasses the pending buffer and discards whatever was waiting there.
      if (fb) begin
        if (load) begin
          shadow  <= value_in;
          pending <= 1'b0;
        end else if (pending) begin
          shadow  <= pend_val;
          pending <= 1'b0;
        end
      end else if (load) begin
        pend_val <= value_in;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_four_digit_scan_ctrl.sv
// Purpose : self-checking bench for four_digit_scan_ctrl with a cycle-level reference model.
// Latency : model predicts the registered outputs one cycle after the inputs that produce them.
// Backpr. : n/a.

module tb_four_digit_scan_ctrl;

  localparam int P = 4;
  localparam int G = 1;
  localparam int FRAME = 4 * P;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic [3:0]  nib;
  logic [3:0]  an;
  logic        dp_n;
  logic        pending;
  logic        frame_tick;

  four_digit_scan_ctrl #(.PRESCALE(P), .GUARD(G)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .value_in   (value_in),
    .load       (load),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .nib        (nib),
    .an         (an),
    .dp_n       (dp_n),
    .pending    (pending),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
  endtask

  // Reference model: scan position is a single counter over the whole frame
  // (digit = pos / P, phase within the slot = pos % P).
  int          m_pos;
  logic [15:0] m_shadow;
  logic [15:0] m_pend;
  logic        m_pending;
  logic [3:0]  m_an;
  logic [3:0]  m_nib;
  logic        m_dp_n;
  logic        m_ft;

  function automatic bit lz_dark(input logic [15:0] sh, input int dg);
`ifdef LEAD_ZERO_BLANK_EN
    if (dg == 0) return 1'b0;
    return (sh >> (4 * dg)) == 16'h0000;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_pos     = 0;
    m_shadow  = 16'h0000;
    m_pend    = 16'h0000;
    m_pending = 1'b0;
    m_an      = 4'b1111;
    m_nib     = 4'h0;
    m_dp_n    = 1'b1;
    m_ft      = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic e, input logic l,
                            input logic [15:0] v, input logic [3:0] d, input logic [3:0] m);
    int dg;
    int ph;
    bit lit;
    bit frame_end;
    if (r) begin
      model_reset();
      return;
    end
    dg        = m_pos / P;
    ph        = m_pos % P;
    m_nib     = 4'((m_shadow >> (4 * dg)) & 16'h000F);
    m_dp_n    = ~d[dg];
    lit       = e && (ph >= G) && !m[dg] && !lz_dark(m_shadow, dg);
    m_an      = lit ? ~(4'b0001 << dg) : 4'b1111;
    frame_end = e && (m_pos == FRAME - 1);
    m_ft      = frame_end;
    if (frame_end) begin
      if (l) begin
        m_shadow  = v;
        m_pending = 1'b0;
      end else if (m_pending) begin
        m_shadow  = m_pend;
        m_pending = 1'b0;
      end
    end else if (l) begin
      m_pend    = v;
      m_pending = 1'b1;
    end
    if (e) m_pos = (m_pos + 1) % FRAME;
  endtask

  task automatic compare_outputs();
    chk("an",         {12'h0, an},         {12'h0, m_an});
    chk("nib",        {12'h0, nib},        {12'h0, m_nib});
    chk("dp_n",       {15'h0, dp_n},       {15'h0, m_dp_n});
    chk("pending",    {15'h0, pending},    {15'h0, m_pending});
    chk("frame_tick", {15'h0, frame_tick}, {15'h0, m_ft});
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance model, take the edge.
  task automatic cyc(input logic r, input logic e, input logic l,
                     input logic [15:0] v, input logic [3:0] d, input logic [3:0] m);
    rst        = r;
    en         = e;
    load       = l;
    value_in   = v;
    dp_in      = d;
    blank_mask = m;
    @(negedge clk);
    compare_outputs();
    model_step(r, e, l, v, d, m);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [3:0] d, input logic [3:0] m);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0000, d, m);
  endtask

  // Advance (bounded) until the next cycle is the frame boundary.
  task automatic to_boundary();
    for (int t = 0; t < FRAME + 2 && m_pos != FRAME - 1; t++)
      cyc(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 4'h0);
  endtask

  logic [3:0]  rd;
  logic [3:0]  rm;
  logic [15:0] rv;

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    load       = 1'b0;
    value_in   = 16'h0000;
    dp_in      = 4'h0;
    blank_mask = 4'h0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 4'h0);

    // Free-running scan after reset, nothing loaded.
    run(40, 4'h0, 4'h0);

    // Load mid-frame; appears from the next frame boundary.
    run(5, 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 1'b1, 16'hA5C3, 4'h0, 4'h0);
    run(40, 4'h0, 4'h0);

    // Two loads in one frame: only the latest is shown.
    to_boundary();
    run(3, 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 1'b1, 16'h1111, 4'h0, 4'h0);
    run(2, 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 1'b1, 16'h2222, 4'h0, 4'h0);
    run(36, 4'h0, 4'h0);

    // Load on the exact boundary while another value is pending.
    run(2, 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 1'b1, 16'h1234, 4'h0, 4'h0);
    to_boundary();
    cyc(1'b0, 1'b1, 1'b1, 16'h7777, 4'h0, 4'h0);
    run(36, 4'h0, 4'h0);

    // Blank mask, decimal point, and a mid-slot pause.
    run(21, 4'b0001, 4'b0100);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0000, 4'b0001, 4'b0100);
    cyc(1'b0, 1'b0, 1'b1, 16'h9876, 4'b0001, 4'b0100);
    run(40, 4'b0001, 4'b0100);

    // Reset mid-frame with a value pending.
    run(3, 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 1'b1, 16'hBEEF, 4'h0, 4'h0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 4'h0, 4'h0);
    run(40, 4'h0, 4'h0);

`ifdef LEAD_ZERO_BLANK_EN
    to_boundary();
    cyc(1'b0, 1'b1, 1'b1, 16'h0000, 4'h0, 4'h0);
    run(32, 4'h0, 4'h0);
    to_boundary();
    cyc(1'b0, 1'b1, 1'b1, 16'h0400, 4'h0, 4'h0);
    run(32, 4'h0, 4'h0);
`endif

    // Randomised traffic.
    rd = 4'h0;
    rm = 4'h0;
    for (int k = 0; k < 2000; k++) begin
      rv = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rv = rv & 16'h00FF;
      if ($urandom_range(0, 7) == 0) rv = 16'h0000;
      if ($urandom_range(0, 31) == 0) rd = 4'($urandom);
      if ($urandom_range(0, 31) == 0) rm = 4'($urandom) & 4'($urandom);
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 5) == 0), rv, rd, rm);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/four_digit_scan_ctrl.md
Name: four_digit_scan_ctrl

Overview:
- Time-multiplexing scan controller for the four-digit seven-segment display driver.
- Holds a 16-bit display value and steps through the digits in turn. Each slot drives the digit's nibble into the existing hex seven-segment decoder, drives the matching active-low anode, and drives the decimal point.
- Value updates are double-buffered and applied only at frame boundaries, so the display never shows a half-updated value.

Parameters:
- PRESCALE, 50000, clk cycles per digit slot; legal range >= 2.
- GUARD, 2, blanking cycles at the start of each slot (anodes all off, anti-ghosting); legal range 0 .. PRESCALE-1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable; 0 freezes counters and blanks all anodes.
- value_in  in  16  new display value; nibble i is shown on digit i, digit 0 is rightmost.
- load  in  1  one-cycle strobe that captures value_in into the pending buffer.
- dp_in  in  4  decimal-point request per digit, active-high.
- blank_mask  in  4  bit i = 1 forces digit i dark.
- nib  out  4  nibble for the current digit; connects to the decoder's s input.
- an  out  4  digit anodes, active-low, one-hot-low or all ones.
- dp_n  out  1  decimal point, active-low.
- pending  out  1  1 while a loaded value is waiting for the frame boundary.
- frame_tick  out  1  one-cycle pulse when digit 3's slot ends.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values (all registers): cnt=0, idx=0, shadow=16'h0000, pend_val=0, pending=0, an=4'b1111, nib=4'h0, dp_n=1, frame_tick=0.
- Slot counter:
  - cnt counts 0..PRESCALE-1 while en=1; tc = en & (cnt==PRESCALE-1).
  - On tc: cnt<=0 and idx<=idx+1 mod 4 (wraps 3->0).
  - en=0 holds cnt and idx.
- Frame boundary: fb = tc & (idx==3). frame_tick is registered and equals fb delayed by one cycle.
- Outputs are registered and lag cnt/idx by one cycle:
  - nib <= shadow[4*idx +: 4].
  - dp_n <= ~dp_in[idx].
  - an <= 4'b1111 if en=0, or cnt < GUARD, or blank_mask[idx]=1 (or the optional feature blanks the digit).
  - Otherwise an <= ~(4'b0001 << idx).
  - nib and dp_n update even while the anodes are blanked.
- First cycle after rst deasserts with en=1 and GUARD=0: an=4'b1110 and nib=shadow[3:0].
- Load handshake:
  - load & ~fb: pend_val<=value_in and pending<=1.
  - load while pending=1: overwrite pend_val; the latest value wins and no error is raised.
  - fb & pending & ~load: shadow<=pend_val and pending<=0.
  - fb & load: shadow<=value_in directly and pending stays/becomes 0. Any older pend_val is discarded.
  - fb & ~pending & ~load: shadow is unchanged.
- en=0 with a pending load: the value stays pending until scanning resumes and reaches a boundary.
- rst mid-frame: all state returns to reset values on the next edge, including discarding any pending value. Scanning restarts at digit 0 with cnt=0.
- The prescale counter width is $clog2(PRESCALE); no other arithmetic overflow is possible.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined: leading-zero blanking, evaluated on shadow.
  - Digit i is dark if every nibble from shadow[4*i+:4] up to nibble 3 is zero.
  - Digit 0 is never blanked by this rule.
  - ORed with blank_mask.
  - Example: shadow=16'h0040 lights digits 1 and 0 only.
- Undefined: all four digits are shown, including zeros. No extra logic is generated.

Test Plan (PRESCALE=4, GUARD=1 unless noted):
- Reset, then en=1, no load: an cycles 1111, 1110 x3, 1111, 1101 x3, 1111, 1011 x3, 1111, 0111 x3, repeating; nib=0 throughout; frame_tick pulses every 16 cycles.
- Load 16'hA5C3 mid-frame: pending=1 until the boundary. The next frame shows nib 3, C, 5, A on an[0..3]; pending=0 after the boundary.
- Two loads in one frame (16'h1111 then 16'h2222): only 2222 is ever displayed.
- Load 16'h7777 on exactly the boundary cycle while 16'h1234 is pending: shadow=7777, pending=0, and 1234 is never shown.
- blank_mask=4'b0100 and dp_in=4'b0001: digit 2 stays dark; dp_n=0 only during digit-0 slots. en=0 mid-slot gives an=1111 with idx frozen; scanning resumes at the same digit and cnt.
- LEAD_ZERO_BLANK_EN defined, value 16'h0000: only digit 0 lights, showing 0. Value 16'h0400: digits 2..0 light; digit 3 stays dark.
